// File: rtl/multicycle_core.sv
// Multi-cycle 3-bit-opcode core: FETCH/DECODE/EXEC/MEM/WB/HALT with req/ack memory ports.
// Optional 16-bit retired-instruction counter enabled by MULTICYCLE_CORE_RETIRE_CNT_EN.
module multicycle_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int IMM_W  = 3,
  parameter int ADDR_W = 8,
  localparam int INSTR_W = 3 + 2*REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic               if_req,
  output logic [ADDR_W-1:0]  if_addr,
  input  logic               if_ack,
  input  logic [INSTR_W-1:0] if_data,
  output logic               dm_req,
  output logic               dm_we,
  output logic [ADDR_W-1:0]  dm_addr,
  output logic [DATA_W-1:0]  dm_wdata,
  input  logic               dm_ack,
  input  logic [DATA_W-1:0]  dm_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [2:0]         state
`ifdef MULTICYCLE_CORE_RETIRE_CNT_EN
  ,
  output logic [15:0]        retire_cnt
`endif
);

  localparam int NREGS = 2**REG_AW;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  function automatic logic [DATA_W-1:0] sext_d(input logic signed [IMM_W-1:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic [ADDR_W-1:0] sext_a(input logic signed [IMM_W-1:0] v);
    return ADDR_W'(v);
  endfunction

  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
    return ADDR_W'(v);
  endfunction

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]    a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic                 if_req_q, if_req_d;
  logic                 dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [ADDR_W-1:0]    dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0]    dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0]    rf_q [NREGS];
  logic                 rf_we;

  logic [2:0]                  op;
  logic [REG_AW-1:0]           rd, rs;
  logic signed [IMM_W-1:0]     imm;

  assign op  = ir_q[INSTR_W-1 -: 3];
  assign rd  = ir_q[IMM_W + 2*REG_AW - 1 -: REG_AW];
  assign rs  = ir_q[IMM_W + REG_AW - 1 -: REG_AW];
  assign imm = ir_q[IMM_W-1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    if_req_d   = if_req_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    rf_we      = 1'b0;
    case (state_q)
      S_FETCH: begin
        // An ack only counts while our request is actually up.
        if (if_req_q && if_ack) begin
          ir_d     = if_data;
          if_req_d = 1'b0;
          state_d  = S_DECODE;
        end else begin
          if_req_d = 1'b1;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[rd];
        b_d     = rf_q[rs];
        state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_ADD:  begin alu_d = a_q + b_q;         state_d = S_WB; end
          OP_SUB:  begin alu_d = a_q - b_q;         state_d = S_WB; end
          OP_ADDI: begin alu_d = a_q + sext_d(imm); state_d = S_WB; end
          OP_AND:  begin alu_d = a_q & b_q;         state_d = S_WB; end
          OP_LW, OP_SW: begin
            dm_addr_d  = to_addr(b_q + sext_d(imm));
            dm_we_d    = (op == OP_SW);
            dm_wdata_d = a_q;
            dm_req_d   = 1'b1;
            state_d    = S_MEM;
          end
          OP_BEQ: begin
            pc_d     = (a_q == b_q) ? pc_q + ADDR_W'(1) + sext_a(imm) : pc_q + ADDR_W'(1);
            if_req_d = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (dm_req_q && dm_ack) begin
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
          if (op == OP_SW) begin
            pc_d     = pc_q + ADDR_W'(1);
            if_req_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            alu_d   = dm_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        pc_d     = pc_q + ADDR_W'(1);
        if_req_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        if_req_d = 1'b0;
        dm_req_d = 1'b0;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      if_req_q   <= 1'b0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      if_req_q   <= if_req_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      if (rf_we) rf_q[rd] <= alu_q;
    end
  end

  assign if_req   = if_req_q;
  assign if_addr  = pc_q;
  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign pc       = pc_q;
  assign halted   = (state_q == S_HALT);
  assign state    = state_q;

`ifdef MULTICYCLE_CORE_RETIRE_CNT_EN
  logic [15:0] retire_q;
  logic        retire;

  // HALT retires as it is entered; every other op retires on its final state exit.
  always_comb begin
    retire = (state_q == S_WB)
          || (state_q == S_EXEC && op == OP_BEQ)
          || (state_q == S_MEM && dm_req_q && dm_ack && op == OP_SW)
          || (state_q == S_DECODE && op == OP_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                retire_q <= '0;
    else if (retire && retire_q != 16'hFFFF)  retire_q <= retire_q + 16'd1;
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: memory responders with wait states, plus an ISA-level reference model.
`timescale 1ns/1ps
module tb_multicycle_core;

  logic       clk;
  logic       reset;
  logic       if_req, if_ack, dm_req, dm_we, dm_ack, halted;
  logic [7:0] if_addr, dm_addr, dm_wdata, dm_rdata, pc;
  logic [9:0] if_data;
  logic [2:0] state;
`ifdef MULTICYCLE_CORE_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  multicycle_core dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .pc(pc), .halted(halted), .state(state)
`ifdef MULTICYCLE_CORE_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_err;
  int if_wait, dm_wait, if_cnt, dm_cnt, stab_err;
  bit spur;
  logic [9:0] imem [256];
  logic [7:0] dmem [256];
  logic       prev_if_req, prev_dm_req;
  logic [7:0] prev_if_addr;
  logic [16:0] prev_dm_sig;

  // reference model state
  int m_reg [4];
  int m_pc, m_ret;
  int mdmem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] enc(input int op, input int rd, input int rs, input int imm);
    return {op[2:0], rd[1:0], rs[1:0], imm[2:0]};
  endfunction

  // Memory responders: ack after if_wait/dm_wait extra cycles of req; optional stray acks while idle.
  always @(negedge clk) begin
    if (if_req) begin
      if (prev_if_req && if_addr !== prev_if_addr) stab_err++;
      if (if_cnt >= if_wait) begin if_ack = 1'b1; if_data = imem[if_addr]; end
      else begin if_ack = 1'b0; if_data = 10'($urandom); end
      if_cnt++;
    end else begin
      if_cnt  = 0;
      if_ack  = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      if_data = 10'($urandom);
    end
    prev_if_req  = if_req;
    prev_if_addr = if_addr;
    if (dm_req) begin
      if (prev_dm_req && {dm_we, dm_addr, dm_wdata} !== prev_dm_sig) stab_err++;
      if (dm_cnt >= dm_wait) begin
        dm_ack = 1'b1;
        if (dm_we) begin dmem[dm_addr] = dm_wdata; dm_rdata = 8'($urandom); end
        else dm_rdata = dmem[dm_addr];
      end else begin
        dm_ack = 1'b0; dm_rdata = 8'($urandom);
      end
      dm_cnt++;
    end else begin
      dm_cnt   = 0;
      dm_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      dm_rdata = 8'($urandom);
    end
    prev_dm_req = dm_req;
    prev_dm_sig = {dm_we, dm_addr, dm_wdata};
  end

  task automatic chk_regs();
    chk("r0", 32'(dut.rf_q[0]), 32'(m_reg[0]));
    chk("r1", 32'(dut.rf_q[1]), 32'(m_reg[1]));
    chk("r2", 32'(dut.rf_q[2]), 32'(m_reg[2]));
    chk("r3", 32'(dut.rf_q[3]), 32'(m_reg[3]));
  endtask

  // Caller has reset asserted; checks reset values, releases, checks fetch start.
  task automatic hold_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_pc = 0; m_ret = 0;
    chk("rst_if_req", 32'(if_req), 0);
    chk("rst_dm_req", 32'(dm_req), 0);
    chk("rst_dm_we", 32'(dm_we), 0);
    chk("rst_dm_addr", 32'(dm_addr), 0);
    chk("rst_dm_wdata", 32'(dm_wdata), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_halted", 32'(halted), 0);
    chk_regs();
`ifdef MULTICYCLE_CORE_RETIRE_CNT_EN
    chk("rst_retire", 32'(retire_cnt), 0);
`endif
    if_wait = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_if_req", 32'(if_req), 1);
    chk("rel_state", 32'(state), 0);
    chk("rel_if_addr", 32'(if_addr), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    hold_reset();
  endtask

  // Execute one instruction in the model and check the DUT at its completion point.
  task automatic step();
    logic [9:0] ins;
    int op, rd, rs, imm, simm, a, b, ea, lat, nxt;
    bit halt_now;
    ins  = imem[m_pc];
    op   = int'(ins[9:7]);
    rd   = int'(ins[6:5]);
    rs   = int'(ins[4:3]);
    imm  = int'(ins[2:0]);
    simm = (imm > 3) ? imm - 8 : imm;
    a    = m_reg[rd];
    b    = m_reg[rs];
    ea   = (b + simm) & 255;
    nxt  = (m_pc + 1) & 255;
    lat  = 4 + if_wait;
    halt_now = 1'b0;
    case (op)
      0: m_reg[rd] = (a + b) & 255;
      1: m_reg[rd] = (a - b) & 255;
      2: m_reg[rd] = (a + simm) & 255;
      6: m_reg[rd] = a & b;
      3: begin m_reg[rd] = mdmem[ea]; lat = 5 + if_wait + dm_wait; end
      4: begin mdmem[ea] = a; lat = 4 + if_wait + dm_wait; end
      5: begin lat = 3 + if_wait; if (a == b) nxt = (m_pc + 1 + simm) & 255; end
      default: begin halt_now = 1'b1; lat = 2 + if_wait; nxt = m_pc; end
    endcase
    if (m_ret < 65535) m_ret++;
    if (op == 3 || op == 4) begin
      repeat (3 + if_wait) @(posedge clk); #1;
      chk("mem_state", 32'(state), 3);
      chk("mem_req", 32'(dm_req), 1);
      chk("mem_we", 32'(dm_we), (op == 4) ? 1 : 0);
      chk("mem_addr", 32'(dm_addr), 32'(ea));
      if (op == 4) chk("mem_wdata", 32'(dm_wdata), 32'(a));
      repeat (lat - 3 - if_wait) @(posedge clk); #1;
    end else begin
      repeat (lat) @(posedge clk); #1;
    end
    m_pc = nxt;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("state", 32'(state), halt_now ? 5 : 0);
    chk("if_req", 32'(if_req), halt_now ? 0 : 1);
    chk("halted", 32'(halted), halt_now ? 1 : 0);
    chk_regs();
`ifdef MULTICYCLE_CORE_RETIRE_CNT_EN
    chk("retire", 32'(retire_cnt), 32'(m_ret));
`endif
  endtask

  initial begin
    int reqs, bad;
    n_chk = 0; n_err = 0; stab_err = 0;
    if_wait = 0; dm_wait = 0; if_cnt = 0; dm_cnt = 0; spur = 1'b0;
    if_ack = 1'b0; dm_ack = 1'b0; if_data = '0; dm_rdata = '0;
    prev_if_req = 1'b0; prev_dm_req = 1'b0; prev_if_addr = '0; prev_dm_sig = '0;
    for (int i = 0; i < 256; i++) begin imem[i] = '0; dmem[i] = '0; mdmem[i] = 0; end
    reset = 1'b0;

    // Program A: ADDI/ADDI/ADD, SW/LW with slow data memory, BEQ self-loop at 5
    imem[0] = enc(2, 1, 0, 3);
    imem[1] = enc(2, 2, 0, 6);
    imem[2] = enc(0, 1, 2, 0);
    imem[3] = enc(4, 1, 0, 2);
    imem[4] = enc(3, 3, 0, 2);
    imem[5] = enc(5, 0, 0, 7);
    #2 reset = 1'b1;
    hold_reset();
    repeat (3) step();
    chk("progA_r1", 32'(dut.rf_q[1]), 32'h01);
    dm_wait = 3;
    step(); step();
    chk("progA_r3", 32'(dut.rf_q[3]), 32'h01);
    dm_wait = 0;
    step(); step();

    // Reset during a stalled fetch
    if_wait = 1000;
    repeat (3) @(posedge clk); #1;
    chk("stall_if_req", 32'(if_req), 1);
    chk("stall_pc", 32'(pc), 5);
    #2 reset = 1'b1;
    #1;
    chk("async_if_req", 32'(if_req), 0);
    chk("async_pc", 32'(pc), 0);
    chk("async_state", 32'(state), 0);
    hold_reset();

    // Program B: wraparound arithmetic, SUB/AND, BEQ not-taken and taken
    for (int i = 0; i < 256; i++) imem[i] = '0;
    imem[0] = enc(2, 1, 0, 7);
    imem[1] = enc(2, 2, 0, 2);
    imem[2] = enc(0, 1, 2, 0);
    imem[3] = enc(1, 3, 1, 0);
    imem[4] = enc(6, 3, 2, 0);
    imem[5] = enc(5, 1, 2, 7);
    imem[6] = enc(5, 2, 3, 4);
    if_wait = 1;
    repeat (3) step();
    chk("ovf_r1", 32'(dut.rf_q[1]), 32'h01);
    repeat (3) step();
    chk("beq_ne_pc", 32'(pc), 6);
    step();
    do_reset();

    // Program C: HALT at pc=4 with wait states on both memories
    for (int i = 0; i < 256; i++) imem[i] = '0;
    imem[0] = enc(2, 1, 0, 1);
    imem[1] = enc(4, 1, 1, 3);
    imem[2] = enc(3, 2, 0, 4);
    imem[3] = enc(5, 0, 1, 3);
    imem[4] = enc(7, 0, 0, 0);
    if_wait = 2; dm_wait = 1;
    repeat (5) step();
    reqs = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (if_req !== 1'b0 || dm_req !== 1'b0) reqs++;
    end
    chk("halt_idle_reqs", 32'(reqs), 0);
    chk("halt_pc", 32'(pc), 4);
    chk("halt_flag", 32'(halted), 1);

    // Random programs with PC wrap at start, random waits and stray idle acks
    spur = 1'b1;
    for (int i = 0; i < 256; i++) begin
      imem[i]  = enc($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
      dmem[i]  = 8'($urandom);
      mdmem[i] = int'(dmem[i]);
    end
    imem[0]   = enc(5, 0, 0, 6);
    imem[255] = enc(2, 1, 0, 1);
    do_reset();
    step();
    chk("wrap_to_ff", 32'(pc), 32'hFF);
    step();
    chk("wrap_to_0", 32'(pc), 0);
    for (int k = 0; k < 300; k++) begin
      if_wait = $urandom_range(0, 2);
      dm_wait = $urandom_range(0, 3);
      step();
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== 8'(mdmem[i])) bad++;
    chk("dmem_contents", 32'(bad), 0);
    chk("req_stability", 32'(stab_err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
